// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters
// (core fetch and loader/debug) and the shared synchronous-read memory array.
interface imem_port_arbiter_if #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned MAX_STARVE = 4
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(MAX_STARVE + 1);

  // Fetch port
  logic          f_req_valid;
  logic          f_req_ready;
  logic [31:0]   f_addr;
  logic          f_flush;
  logic          f_rsp_valid;
  logic [31:0]   f_rsp_data;

  // Loader/debug port
  logic          l_req_valid;
  logic          l_req_ready;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_rsp_valid;
  logic [31:0]   l_rsp_data;
  logic          l_rsp_err;

  // Memory array side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // Debug
  logic [SW-1:0] starve_cnt;

  // Arbiter view
  modport slave (
    input  f_req_valid, f_addr, f_flush,
    input  l_req_valid, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output f_req_ready, f_rsp_valid, f_rsp_data,
    output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    output mem_en, mem_we, mem_waddr, mem_wdata,
    output starve_cnt
  );

  // Requester/memory environment view
  modport master (
    output f_req_valid, f_addr, f_flush,
    output l_req_valid, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  f_req_ready, f_rsp_valid, f_rsp_data,
    input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    input  mem_en, mem_we, mem_waddr, mem_wdata,
    input  starve_cnt
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: fixed priority to fetch with a bounded
// wait for the loader, one in-flight read tracked through an owner register,
// range/alignment checks and fetch-flush suppression of stale responses.
module imem_port_arbiter #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned MAX_STARVE = 4,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  imem_port_arbiter_if.slave bus
);
  localparam int unsigned   AW         = $clog2(DEPTH);
  localparam int unsigned   SW         = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  // Owner of the response due next cycle
  owner_e        r_own;
  owner_e        w_own_nxt;
  logic          r_own_oob;
  logic          w_oob_nxt;
  logic          r_own_wr;
  logic          w_wr_nxt;

  // Loader wait counter
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_nxt;

  // Address decode
  logic [31:0]   w_f_word;
  logic [31:0]   w_l_word;
  logic          w_f_in_range;
  logic          w_l_in_range;

  // Grants
  logic          w_grant_f;
  logic          w_grant_l;

  // Memory drive
  logic          w_mem_en;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [31:0]   w_mem_wdata;

  // Responses
  logic          w_f_rsp_valid;
  logic [31:0]   w_f_rsp_data;
  logic          w_l_rsp_valid;
  logic [31:0]   w_l_rsp_data;
  logic          w_l_rsp_err;

  // Fetch ignores the byte offset; the loader must be word aligned.
  assign w_f_word     = bus.f_addr >> 2;
  assign w_l_word     = bus.l_addr >> 2;
  assign w_f_in_range = (w_f_word < 32'(DEPTH));
  assign w_l_in_range = (w_l_word < 32'(DEPTH)) && (bus.l_addr[1:0] == 2'b00);

  // Single grant per cycle: a starved loader wins, else fetch, else loader
  always_comb begin
    w_grant_f = 1'b0;
    w_grant_l = 1'b0;
    if (!rst) begin
      if (bus.l_req_valid && (r_starve == STARVE_MAX)) begin
        w_grant_l = 1'b1;
      end else if (bus.f_req_valid) begin
        w_grant_f = 1'b1;
      end else if (bus.l_req_valid) begin
        w_grant_l = 1'b1;
      end
    end
  end

  // Drive the array in the grant cycle; out-of-range requests never touch it
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = '0;
    if (w_grant_f && w_f_in_range) begin
      w_mem_en    = 1'b1;
      w_mem_waddr = w_f_word[AW-1:0];
    end else if (w_grant_l && w_l_in_range) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.l_we;
      w_mem_waddr = w_l_word[AW-1:0];
      w_mem_wdata = bus.l_we ? bus.l_wdata : '0;
    end
  end

  // Owner of the upcoming response, captured at the grant edge
  always_comb begin
    w_own_nxt = OWN_NONE;
    w_oob_nxt = 1'b0;
    w_wr_nxt  = 1'b0;
    if (w_grant_f) begin
      w_own_nxt = OWN_FETCH;
      w_oob_nxt = !w_f_in_range;
    end else if (w_grant_l) begin
      w_own_nxt = OWN_LOAD;
      w_oob_nxt = !w_l_in_range;
      w_wr_nxt  = bus.l_we;
    end
  end

  // Owner register; async reset drops any pending response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own     <= OWN_NONE;
      r_own_oob <= 1'b0;
      r_own_wr  <= 1'b0;
    end else begin
      r_own     <= w_own_nxt;
      r_own_oob <= w_oob_nxt;
      r_own_wr  <= w_wr_nxt;
    end
  end

  // Loader wait count: saturating, cleared on loader grant or idle loader
  always_comb begin
    w_starve_nxt = r_starve;
    if (!bus.l_req_valid || w_grant_l) begin
      w_starve_nxt = '0;
    end else if (r_starve != STARVE_MAX) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  // Loader wait counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end

  // Route the response to its owner. A fetch accepted alongside f_flush is
  // post-flush, so only a flush seen in the response cycle itself kills it.
  always_comb begin
    w_f_rsp_valid = 1'b0;
    w_f_rsp_data  = '0;
    w_l_rsp_valid = 1'b0;
    w_l_rsp_data  = '0;
    w_l_rsp_err   = 1'b0;
    case (r_own)
      OWN_FETCH: begin
        if (!bus.f_flush) begin
          w_f_rsp_valid = 1'b1;
          w_f_rsp_data  = r_own_oob ? NOP_WORD : bus.mem_rdata;
        end
      end
      OWN_LOAD: begin
        w_l_rsp_valid = 1'b1;
        w_l_rsp_err   = r_own_oob;
        if (!r_own_oob && !r_own_wr) begin
          w_l_rsp_data = bus.mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.f_req_ready = w_grant_f;
  assign bus.l_req_ready = w_grant_l;
  assign bus.f_rsp_valid = w_f_rsp_valid;
  assign bus.f_rsp_data  = w_f_rsp_data;
  assign bus.l_rsp_valid = w_l_rsp_valid;
  assign bus.l_rsp_data  = w_l_rsp_data;
  assign bus.l_rsp_err   = w_l_rsp_err;
  assign bus.mem_en      = w_mem_en;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_waddr   = w_mem_waddr;
  assign bus.mem_wdata   = w_mem_wdata;
  assign bus.starve_cnt  = r_starve;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_imem_port_arbiter;
  localparam int unsigned DEPTH      = 1024;
  localparam int unsigned MAX_STARVE = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic clk;
  logic rst;

  imem_port_arbiter_if #(.DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE)) ifc ();

  imem_port_arbiter #(.DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory array attached to the arbiter
  logic [31:0] phys [DEPTH];
  always @(posedge clk) begin
    if (ifc.mem_en) begin
      if (ifc.mem_we) phys[ifc.mem_waddr] <= ifc.mem_wdata;
      else            ifc.mem_rdata <= phys[ifc.mem_waddr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          m_pend;        // 0 none, 1 fetch, 2 loader
  logic [31:0] m_pend_data;
  logic        m_pend_err;
  int          m_starve;

  // Current cycle inputs and predictions
  logic        c_fv, c_ff, c_lv, c_lwe;
  logic [31:0] c_fa, c_la, c_lwd;
  logic        e_fg, e_lg, e_fok, e_lok;
  logic        exp_fr, exp_lr, exp_en, exp_we, exp_fv, exp_lv, exp_le;
  logic [31:0] exp_fd, exp_ld, exp_wd;
  logic [9:0]  exp_wa;
  logic [2:0]  exp_st;

  task automatic model_reset();
    m_pend      = 0;
    m_pend_data = '0;
    m_pend_err  = 1'b0;
    m_starve    = 0;
  endtask

  task automatic drive(input logic fv, input logic [31:0] fa, input logic ff,
                       input logic lv, input logic lwe, input logic [31:0] la,
                       input logic [31:0] lwd);
    int unsigned fw;
    int unsigned lw;
    @(negedge clk);
    c_fv = fv; c_fa = fa; c_ff = ff; c_lv = lv; c_lwe = lwe; c_la = la; c_lwd = lwd;
    ifc.f_req_valid = fv; ifc.f_addr = fa; ifc.f_flush = ff;
    ifc.l_req_valid = lv; ifc.l_we = lwe; ifc.l_addr = la; ifc.l_wdata = lwd;
    fw    = fa >> 2;
    lw    = la >> 2;
    e_lg  = lv && ((m_starve == MAX_STARVE) || !fv);
    e_fg  = fv && !e_lg;
    e_fok = fw < DEPTH;
    e_lok = (lw < DEPTH) && ((la % 4) == 0);
    exp_fr = e_fg;
    exp_lr = e_lg;
    exp_st = 3'(m_starve);
    exp_en = (e_fg && e_fok) || (e_lg && e_lok);
    exp_we = e_lg && e_lok && lwe;
    exp_wa = e_fg ? 10'(fw % DEPTH) : 10'(lw % DEPTH);
    exp_wd = lwd;
    exp_fv = (m_pend == 1) && !ff;
    exp_fd = exp_fv ? m_pend_data : 32'h0;
    exp_lv = (m_pend == 2);
    exp_le = exp_lv && m_pend_err;
    exp_ld = exp_lv ? m_pend_data : 32'h0;
    #1;
  endtask

  task automatic advance();
    int unsigned fw;
    int unsigned lw;
    @(posedge clk);
    fw = c_fa >> 2;
    lw = c_la >> 2;
    if (e_fg) begin
      m_pend      = 1;
      m_pend_err  = 1'b0;
      m_pend_data = e_fok ? ref_mem[fw] : NOP;
    end else if (e_lg) begin
      m_pend      = 2;
      m_pend_err  = !e_lok;
      m_pend_data = (!e_lok || c_lwe) ? 32'h0 : ref_mem[lw];
      if (e_lok && c_lwe) ref_mem[lw] = c_lwd;
    end else begin
      m_pend = 0;
    end
    if (e_lg || !c_lv) m_starve = 0;
    else if (m_starve < MAX_STARVE) m_starve = m_starve + 1;
  endtask

  task automatic idle_inputs();
    ifc.f_req_valid = 1'b0; ifc.f_addr = '0; ifc.f_flush = 1'b0;
    ifc.l_req_valid = 1'b0; ifc.l_we = 1'b0; ifc.l_addr = '0; ifc.l_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.f_req_valid = 1'b1; ifc.f_addr = 32'h4; ifc.f_flush = 1'b0;
    ifc.l_req_valid = 1'b1; ifc.l_we = 1'b1; ifc.l_addr = 32'h8; ifc.l_wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ifc.f_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_f_req_ready got=%b exp=0", ifc.f_req_ready); end
    n_checks++; if (ifc.l_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_l_req_ready got=%b exp=0", ifc.l_req_ready); end
    n_checks++; if (ifc.mem_en !== 1'b0 || ifc.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem got en=%b we=%b exp 0", ifc.mem_en, ifc.mem_we); end
    n_checks++; if (ifc.f_rsp_valid !== 1'b0 || ifc.l_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got f=%b l=%b exp 0", ifc.f_rsp_valid, ifc.l_rsp_valid); end
    n_checks++; if (ifc.starve_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_starve got=%0d exp=0", ifc.starve_cnt); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fetch_stream();
    // Load a small window through the loader port
    for (int unsigned w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = (w == 0) ? 32'hAA : (w == 1) ? 32'hBB : (w == 2) ? 32'hCC : 32'h5A00_0000 + w;
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1, w << 2, d);
      advance();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 32'(i * 4), 1'b0, 1'b0, 1'b0, '0, '0);
      if (i < 3) begin
        n_checks++; if (ifc.f_req_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready cyc=%0d got=%b exp=1", i, ifc.f_req_ready); end
      end
      n_checks++; if (ifc.f_rsp_valid !== exp_fv) begin n_fail++; $display("FAIL stream_rsp_valid cyc=%0d got=%b exp=%b", i, ifc.f_rsp_valid, exp_fv); end
      n_checks++; if (ifc.f_rsp_data !== exp_fd) begin n_fail++; $display("FAIL stream_rsp_data cyc=%0d got=%h exp=%h", i, ifc.f_rsp_data, exp_fd); end
      advance();
    end
  endtask

  task automatic test_write_then_fetch();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    n_checks++; if (ifc.mem_we !== 1'b1 || ifc.mem_waddr !== 10'd4) begin n_fail++; $display("FAIL wr_mem got we=%b addr=%0d exp we=1 addr=4", ifc.mem_we, ifc.mem_waddr); end
    advance();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++; if (ifc.l_rsp_valid !== 1'b1 || ifc.l_rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp got valid=%b err=%b exp valid=1 err=0", ifc.l_rsp_valid, ifc.l_rsp_err); end
    n_checks++; if (ifc.l_rsp_data !== 32'h0) begin n_fail++; $display("FAIL wr_rsp_data got=%h exp=0", ifc.l_rsp_data); end
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++; if (ifc.f_rsp_valid !== 1'b1 || ifc.f_rsp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_fetch got valid=%b data=%h exp valid=1 data=deadbeef", ifc.f_rsp_valid, ifc.f_rsp_data); end
    advance();
  endtask

  task automatic test_starve();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'(4 * (i % 3)), 1'b0, !done, 1'b0, 32'h20, '0);
      n_checks++; if (ifc.starve_cnt !== exp_st) begin n_fail++; $display("FAIL starve_cnt cyc=%0d got=%0d exp=%0d", i, ifc.starve_cnt, exp_st); end
      n_checks++; if (ifc.l_req_ready !== exp_lr || ifc.f_req_ready !== exp_fr) begin n_fail++; $display("FAIL starve_grant cyc=%0d got l=%b f=%b exp l=%b f=%b", i, ifc.l_req_ready, ifc.f_req_ready, exp_lr, exp_fr); end
      n_checks++; if (ifc.l_rsp_valid !== exp_lv || ifc.l_rsp_data !== exp_ld) begin n_fail++; $display("FAIL starve_lrsp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, ifc.l_rsp_valid, ifc.l_rsp_data, exp_lv, exp_ld); end
      if (i == 4) begin
        n_checks++; if (ifc.l_req_ready !== 1'b1) begin n_fail++; $display("FAIL starve_force cyc=4 got=%b exp=1", ifc.l_req_ready); end
      end
      if (exp_lr) done = 1'b1;
      advance();
    end
  endtask

  task automatic test_oob();
    drive(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++; if (ifc.mem_en !== 1'b0) begin n_fail++; $display("FAIL oob_fetch_en got=%b exp=0", ifc.mem_en); end
    advance();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h2, '0);
    n_checks++; if (ifc.f_rsp_valid !== 1'b1 || ifc.f_rsp_data !== 32'h0000_0013) begin n_fail++; $display("FAIL oob_fetch_nop got v=%b d=%h exp v=1 d=00000013", ifc.f_rsp_valid, ifc.f_rsp_data); end
    n_checks++; if (ifc.mem_en !== 1'b0) begin n_fail++; $display("FAIL oob_load_en got=%b exp=0", ifc.mem_en); end
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++; if (ifc.l_rsp_valid !== 1'b1 || ifc.l_rsp_err !== 1'b1 || ifc.l_rsp_data !== 32'h0) begin n_fail++; $display("FAIL oob_load_err got v=%b e=%b d=%h exp v=1 e=1 d=0", ifc.l_rsp_valid, ifc.l_rsp_err, ifc.l_rsp_data); end
    advance();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    advance();
    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, '0, '0);
    n_checks++; if (ifc.f_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill got=%b exp=0", ifc.f_rsp_valid); end
    n_checks++; if (ifc.f_req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", ifc.f_req_ready); end
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++; if (ifc.f_rsp_valid !== 1'b1 || ifc.f_rsp_data !== 32'hBB) begin n_fail++; $display("FAIL flush_post got v=%b d=%h exp v=1 d=bb", ifc.f_rsp_valid, ifc.f_rsp_data); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h8, '0);
    n_checks++; if (ifc.l_req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_grant got=%b exp=1", ifc.l_req_ready); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ifc.l_rsp_valid !== 1'b0 || ifc.l_rsp_data !== 32'h0) begin n_fail++; $display("FAIL rmid_rsp got v=%b d=%h exp 0", ifc.l_rsp_valid, ifc.l_rsp_data); end
    n_checks++; if (ifc.l_req_ready !== 1'b0 || ifc.mem_en !== 1'b0) begin n_fail++; $display("FAIL rmid_outs got ready=%b en=%b exp 0", ifc.l_req_ready, ifc.mem_en); end
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      n_checks++; if (ifc.l_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_after cyc=%0d got=%b exp=0", i, ifc.l_rsp_valid); end
      advance();
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 15)) << 2;
    else if (r == 7) return 32'(DEPTH + $urandom_range(0, 3)) << 2;
    else if (r == 8) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    else             return 32'hFFFF_FFFC;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd_addr(), $urandom);
      n_checks++; if (ifc.f_req_ready !== exp_fr || ifc.l_req_ready !== exp_lr) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got f=%b l=%b exp f=%b l=%b", i, ifc.f_req_ready, ifc.l_req_ready, exp_fr, exp_lr); end
      n_checks++; if (ifc.starve_cnt !== exp_st) begin n_fail++; $display("FAIL rnd_starve cyc=%0d got=%0d exp=%0d", i, ifc.starve_cnt, exp_st); end
      n_checks++; if (ifc.mem_en !== exp_en || ifc.mem_we !== exp_we) begin n_fail++; $display("FAIL rnd_mem cyc=%0d got en=%b we=%b exp en=%b we=%b", i, ifc.mem_en, ifc.mem_we, exp_en, exp_we); end
      if (exp_en) begin
        n_checks++; if (ifc.mem_waddr !== exp_wa) begin n_fail++; $display("FAIL rnd_waddr cyc=%0d got=%0d exp=%0d", i, ifc.mem_waddr, exp_wa); end
      end
      if (exp_we) begin
        n_checks++; if (ifc.mem_wdata !== exp_wd) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", i, ifc.mem_wdata, exp_wd); end
      end
      n_checks++; if (ifc.f_rsp_valid !== exp_fv || ifc.f_rsp_data !== exp_fd) begin n_fail++; $display("FAIL rnd_frsp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, ifc.f_rsp_valid, ifc.f_rsp_data, exp_fv, exp_fd); end
      n_checks++; if (ifc.l_rsp_valid !== exp_lv || ifc.l_rsp_err !== exp_le || ifc.l_rsp_data !== exp_ld) begin n_fail++; $display("FAIL rnd_lrsp cyc=%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h", i, ifc.l_rsp_valid, ifc.l_rsp_err, ifc.l_rsp_data, exp_lv, exp_le, exp_ld); end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    for (int unsigned w = 0; w < DEPTH; w++) ref_mem[w] = '0;
    test_reset();
    test_fetch_stream();
    test_write_then_fetch();
    test_starve();
    test_oob();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete got=running exp=done");
    $fatal(1);
  end

endmodule
